// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline and byte-memory signal bundle for mem_access_ctrl
interface mem_access_ctrl_if;
   logic        req_read_i;
   logic        req_write_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [7:0]  mem_rdata_i;

   modport slave (
      input  req_read_i, req_write_i, addr_i, wdata_i, mem_rdata_i,
      output rdata_o, busy_o, done_o, err_o,
      output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
   );

   modport master (
      output req_read_i, req_write_i, addr_i, wdata_i, mem_rdata_i,
      input  rdata_o, busy_o, done_o, err_o,
      input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - word load/store serialised into four big-endian byte accesses
module mem_access_ctrl (
   input logic             clk_i,
   input logic             rst_i,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t      state;
   logic [1:0]  k;
   logic [29:0] word_addr;
   logic [31:0] wdata_q;
   logic [31:0] asm_q;
   logic        is_write;

   logic req;
   logic aligned;
   logic accept;

   assign req     = bus.req_read_i | bus.req_write_i;
   assign aligned = (bus.addr_i[1:0] == 2'b00);
   assign accept  = (state == IDLE) && req && aligned;

   // Stall and error must be visible in the request cycle itself.
   assign bus.busy_o = accept || (state == XFER);
   assign bus.err_o  = (state == IDLE) && req && !aligned;

   function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   function automatic logic [31:0] be_put(input logic [31:0] w, input logic [1:0] idx,
                                          input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (idx)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         k               <= 2'd0;
         word_addr       <= '0;
         wdata_q         <= '0;
         asm_q           <= '0;
         is_write        <= 1'b0;
         bus.rdata_o     <= '0;
         bus.done_o      <= 1'b0;
         bus.mem_addr_o  <= '0;
         bus.mem_wdata_o <= '0;
         bus.mem_read_o  <= 1'b0;
         bus.mem_write_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done_o <= 1'b0;
               if (accept) begin
                  // Write wins when both requests are raised; the read is dropped.
                  word_addr       <= bus.addr_i[31:2];
                  wdata_q         <= bus.wdata_i;
                  is_write        <= bus.req_write_i;
                  k               <= 2'd0;
                  state           <= XFER;
                  bus.mem_addr_o  <= {bus.addr_i[31:2], 2'b00};
                  bus.mem_write_o <= bus.req_write_i;
                  bus.mem_read_o  <= !bus.req_write_i;
                  bus.mem_wdata_o <= bus.req_write_i ? bus.wdata_i[31:24] : 8'h00;
               end
            end
            XFER: begin
               if (!is_write)
                  asm_q <= be_put(asm_q, k, bus.mem_rdata_i);
               if (k == 2'd3) begin
                  state           <= DONE;
                  k               <= 2'd0;
                  bus.done_o      <= 1'b1;
                  bus.mem_addr_o  <= '0;
                  bus.mem_wdata_o <= '0;
                  bus.mem_read_o  <= 1'b0;
                  bus.mem_write_o <= 1'b0;
                  // Last byte arrives on this edge, so merge it directly into the result.
                  if (!is_write)
                     bus.rdata_o <= be_put(asm_q, k, bus.mem_rdata_i);
               end else begin
                  k               <= k + 2'd1;
                  bus.mem_addr_o  <= {word_addr, k + 2'd1};
                  bus.mem_wdata_o <= is_write ? be_byte(wdata_q, k + 2'd1) : 8'h00;
               end
            end
            DONE: begin
               bus.done_o <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Word-level load/store initiator between the MEM pipeline stage and the byte-organised data memory. Accepts one 32-bit load or store per request, serialises it into four byte transactions on the memory side in big-endian order, and stalls the pipeline until the word is complete. It is the requesting end of the data-memory interface; the data memory remains the responder.

## Interface
Parameters:
- none.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous reset, active-high
- req_read_i  in  1  load request from MEM stage (level, held while busy_o=1)
- req_write_i  in  1  store request from MEM stage (level, held while busy_o=1)
- addr_i  in  32  word byte-address
- wdata_i  in  32  store data
- rdata_o  out  32  load result, registered
- busy_o  out  1  pipeline stall request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle misalignment pulse
- mem_addr_o  out  32  byte address to data memory
- mem_wdata_o  out  8  byte write data
- mem_read_o  out  1  byte read strobe
- mem_write_o  out  1  byte write strobe
- mem_rdata_i  in  8  byte read data; combinational from memory, valid in the same cycle as mem_addr_o/mem_read_o

## Operation
- States: IDLE, XFER, DONE. Byte index k: 2-bit counter.
- IDLE: when req_write_i or req_read_i is high and addr_i[1:0]==0, latch addr, wdata, op (write has priority if both are high; the read is then dropped), set k=0, go to XFER. If addr_i[1:0]!=0, err_o=1 for that cycle, no latch, no memory strobes, stay IDLE.
- XFER: mem_addr_o={addr[31:2],k}. Store: mem_write_o=1, mem_wdata_o = latched wdata byte k (k=0 -> [31:24], k=3 -> [7:0]). Load: mem_read_o=1, mem_rdata_i captured at edge into assembly register byte k (same big-endian mapping). k increments each cycle; after k=3, go to DONE.
- DONE: done_o=1. For a load, rdata_o takes the assembled word at the edge entering DONE. Requests are ignored in DONE. Always returns to IDLE.
- busy_o = (IDLE and a valid aligned request) or XFER. busy_o is combinational, so the stall is seen in the request cycle. busy_o=0 in DONE; the pipeline advances at the end of DONE.
- Memory strobes are 0 outside XFER. mem_addr_o and mem_wdata_o are 0 outside XFER.
- Address arithmetic never carries past bit 1. No range check; the memory decodes the address.
- rdata_o holds its value across stores and errors; only a completed load updates it.

## Timing
- Reset values: rdata_o=0, busy_o=0, done_o=0, err_o=0, mem_* outputs 0, state IDLE, k=0.
- Request cycle C0 (IDLE); bytes in C1..C4 (XFER, k=0..3); done_o and valid rdata_o in C5 (DONE). Earliest next request is sampled in C6.
- Total: 6 cycles per access, of which 5 are stalled (C0..C4).
- rst_i during XFER: at that edge, all strobes drop for the next cycle, the state returns to IDLE, no done_o is produced, and the partial load data is discarded. A partial store leaves already-written bytes in memory.
- err_o and done_o are never high in the same cycle.

## Test plan
- Store then load: write 0xDEADBEEF to addr 0x8. Memory strobes hit addresses 8,9,10,11 with data DE,AD,BE,EF in C1..C4, and done_o pulses in C5. A following load of 0x8 returns rdata_o=0xDEADBEEF in its DONE cycle, and busy_o is high for exactly 5 cycles.
- Misaligned: load at 0x6 -> err_o=1 for one cycle, busy_o=0, no mem strobes, rdata_o unchanged.
- Simultaneous req_read_i=req_write_i=1 at 0x4 with wdata 0x01020304 -> four write strobes, no read strobes, rdata_o unchanged, done_o once.
- Reset mid-op: assert rst_i in the C2 cycle of a load -> next cycle all outputs are 0 and the state is IDLE. A new load of 0x0 then completes normally with no stale bytes.
- Back-to-back: a load at 0x0 held until done, then a store at 0x4 presented in the DONE cycle -> the store is not started in DONE and is first accepted in the following IDLE cycle.
